wb_broadcast: RTL and testbench
===============================

# wb_broadcast

Writeback broadcast unit: collects completed results from the execute stage and the memory stage and drives them out as the two broadcast channels consumed by the issue queue. Each result is also written into the physical register file and reported to the ROB as complete. The unit owns the 64-entry physical-register ready vector (`busy`) that rename samples at enqueue. Each source has its own FIFO, so producers are decoupled from STALL.

## Interface
- `DEPTH`, 4: entries per source FIFO, power of two, at least 2.
- `CLK` input 1: clock; everything updates on the rising edge.
- `RESET` input 1: synchronous, active-high.
- `STALL` input 1: freezes broadcast/pop; enqueue still allowed.
- `FLUSH` input 1: synchronous squash of all pending results.
- `exe_valid` input 1: execute result present this cycle.
- `exe_map` input 6: destination physical register.
- `exe_val` input 32: result value.
- `exe_instr_num` input 32: ROB tag.
- `mem_valid`, `mem_map`, `mem_val`, `mem_instr_num`: same set as `exe_*`, for the memory stage.
- `rename_alloc` input 1: rename allocated a new destination.
- `rename_alloc_map` input 6: that destination.
- `exe_broadcast` output 1: execute channel valid.
- `exe_broadcast_map` output 6: execute channel register.
- `exe_broadcast_val` output 32: execute channel value.
- `mem_broadcast`, `mem_broadcast_map`, `mem_broadcast_val`: same set as `exe_broadcast*`, for the memory channel.
- `physreg_we` output 2: physical register file write enables; bit 0 = exe channel, bit 1 = mem channel.
- `rob_done_exe` output 1, `rob_done_exe_num` output 32: ROB completion for the exe channel.
- `rob_done_mem` output 1, `rob_done_mem_num` output 32: ROB completion for the mem channel.
- `busy` output 64: 1 = register holds its final value.
- `exe_full` output 1, `mem_full` output 1: FIFO at DEPTH.
- `overflow` output 1: sticky; set when an input is dropped.

## Operation
- **Reset.** Every output resets to 0, with two exceptions:
  - `busy` resets to all ones.
  - FIFOs reset empty (pointers and counts 0).
- **FIFOs.** Two independent circular FIFOs (exe, mem). Each entry is {map, val, instr_num} = 70 bits.
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - The count is log2(DEPTH)+1 bits.
- **Push.** On `x_valid`, the entry is pushed if count < DEPTH or a pop occurs in the same cycle.
  - Otherwise the input is dropped and `overflow` is set.
  - `overflow` clears only on RESET.
- **Pop.** When !STALL and the FIFO is non-empty, the head is popped and loaded into the channel output registers. In that same cycle:
  - `x_broadcast`=1.
  - `physreg_we` bit=1.
  - `rob_done_x`=1, with the tag.
- **No pop.** The valid outputs are 0. Map, val and num hold their last values.
- **Ordering.** Each channel is in order. There is no ordering between channels.
- **Busy vector.**
  - On a broadcast, `busy[map]` is set to 1 at the same edge the broadcast goes high.
  - On `rename_alloc`, `busy[rename_alloc_map]` is cleared to 0.
  - Alloc and broadcast to the same map in the same cycle: alloc wins (0).
  - `busy[0]` is forced to 1 always. Results to map 0 are still broadcast and reported to the ROB.
- **STALL.**
  - No pops; all valid outputs are 0.
  - Pushes continue; `full` behaves normally.
  - `busy` updates from alloc continue.
- **FLUSH.**
  - Both FIFOs are emptied and all valid outputs go to 0.
  - `busy` is set to all ones.
  - Inputs in the FLUSH cycle are discarded.
  - `overflow` is unchanged.
  - FLUSH has priority over STALL, push and alloc. RESET has priority over everything.

## Timing
- Input sampled at edge N → entry in FIFO after N → broadcast registered at edge N+1, visible for one cycle.
  - Latency is 2 edges when the FIFO was empty and there is no stall.
- Throughput is one result per channel per cycle; with both channels, two per cycle.
- `busy` set is visible in the same cycle as the broadcast, so rename enqueueing that cycle sees 1.
- The issue queue samples the broadcast on the falling edge of that cycle.
- `x_full` is registered and reflects the count after the edge.
- `x_full` is advisory: a push while full is dropped unless a pop occurs that cycle. This only applies when STALL is low, since STALL blocks pops.

## Configuration
- `WB_BYPASS_EN` defined:
  - When the FIFO is empty, !STALL and `x_valid`, the input goes straight to the output registers at edge N. Latency is 1 edge and the FIFO is not written.
  - `busy` and ROB follow the same edge.
- Not defined: every result passes through the FIFO (2-edge latency).

## Test plan
- **RESET.** Assert RESET 1 cycle → all outputs 0, `busy`=64'hFFFF_FFFF_FFFF_FFFF, full flags 0.
- **Single result.** alloc map 5 → `busy[5]`=0. Then `exe_valid`, map 5, val 0xDEADBEEF, num 7 → two edges later `exe_broadcast`=1, val 0xDEADBEEF, `rob_done_exe_num`=7, `busy[5]`=1. With `WB_BYPASS_EN` this arrives one edge later instead.
- **Stall.** Push 5 exe results back-to-back with STALL high (DEPTH=4) → `exe_full`=1 after 4, `overflow`=1 on the 5th. Release STALL → maps broadcast in order on consecutive cycles, and the 5th is never broadcast.
- **Simultaneous channels.** exe map 3 and mem map 9 in the same cycle → both broadcasts in the same cycle, `physreg_we`=2'b11, `busy[3]`=`busy[9]`=1.
- **Alloc vs broadcast.** alloc map 12 in the same cycle as the broadcast of map 12 → `busy[12]`=0. Map 0 result → broadcast occurs, `busy[0]` remains 1.
- **FLUSH.** FLUSH with 3 entries pending and `busy[20]`=0 → next cycle no broadcasts, counts 0, `busy[20]`=1, `overflow` unchanged.

Source files
------------

// File: rtl/wb_broadcast.sv
// -----------------------------------------------------------------------------
// wb_broadcast
//
// Writeback broadcast unit. Completed results from the execute and memory
// stages each enter their own circular FIFO, which decouples the producers
// from STALL. Every cycle that STALL is low, the head of each non-empty FIFO
// is popped into registered channel outputs. These outputs carry the issue
// queue broadcast, the physical register file write enable and the ROB
// completion. The unit also owns the 64-entry physical-register ready vector
// (`busy`, 1 = final value present) that rename samples at enqueue.
//
// Optional feature macro: WB_BYPASS_EN
//   Defined     - a result that arrives while its FIFO is empty and STALL is
//                 low is loaded straight into the channel outputs at the
//                 sampling edge, which gives 1-edge latency.
//   Not defined - every result passes through its FIFO (2-edge latency).
//
// Parameters
//   DEPTH              entries per source FIFO (power of two, >= 2)
//
// Ports
//   CLK, RESET         clock; synchronous active-high reset
//   STALL              freezes pops/broadcasts; pushes and allocs continue
//   FLUSH              squashes all pending results, sets busy to all ones
//   exe_* / mem_*      result inputs: valid, dest map, value, ROB tag
//   rename_alloc(_map) rename allocated a destination (clears its busy bit)
//   exe_broadcast*     execute channel: valid, map, value
//   mem_broadcast*     memory channel: valid, map, value
//   physreg_we         register file write enables {mem, exe}
//   rob_done_*(_num)   ROB completion per channel with tag
//   busy               physical-register ready vector
//   exe_full/mem_full  registered FIFO-full flags
//   overflow           sticky: an input was dropped
// -----------------------------------------------------------------------------
module wb_broadcast #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        FLUSH,
  input  logic        exe_valid,
  input  logic [5:0]  exe_map,
  input  logic [31:0] exe_val,
  input  logic [31:0] exe_instr_num,
  input  logic        mem_valid,
  input  logic [5:0]  mem_map,
  input  logic [31:0] mem_val,
  input  logic [31:0] mem_instr_num,
  input  logic        rename_alloc,
  input  logic [5:0]  rename_alloc_map,
  output logic        exe_broadcast,
  output logic [5:0]  exe_broadcast_map,
  output logic [31:0] exe_broadcast_val,
  output logic        mem_broadcast,
  output logic [5:0]  mem_broadcast_map,
  output logic [31:0] mem_broadcast_val,
  output logic [1:0]  physreg_we,
  output logic        rob_done_exe,
  output logic [31:0] rob_done_exe_num,
  output logic        rob_done_mem,
  output logic [31:0] rob_done_mem_num,
  output logic [63:0] busy,
  output logic        exe_full,
  output logic        mem_full,
  output logic        overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [5:0]  map;
    logic [31:0] val;
    logic [31:0] num;
  } entry_t;

  // Channel index 0 = exe, 1 = mem throughout.
  entry_t          fifo_q   [2][DEPTH];
  logic [AW-1:0]   wr_ptr_q [2];
  logic [AW-1:0]   wr_ptr_d [2];
  logic [AW-1:0]   rd_ptr_q [2];
  logic [AW-1:0]   rd_ptr_d [2];
  logic [CW-1:0]   count_q  [2];
  logic [CW-1:0]   count_d  [2];
  entry_t          out_q    [2];
  entry_t          out_d    [2];
  logic [1:0]      bcast_q, bcast_d;
  logic [1:0]      full_q, full_d;
  logic [63:0]     busy_q, busy_d;
  logic            overflow_q, overflow_d;

  logic [1:0]      in_valid;
  entry_t          in_entry [2];
  entry_t          head     [2];
  logic [1:0]      pop, push, bypass;

  always_comb begin
    in_valid    = {mem_valid, exe_valid};
    in_entry[0] = {exe_map, exe_val, exe_instr_num};
    in_entry[1] = {mem_map, mem_val, mem_instr_num};
    for (int c = 0; c < 2; c++) begin
      head[c] = fifo_q[c][rd_ptr_q[c]];
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before any branch so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    for (int c = 0; c < 2; c++) begin
      wr_ptr_d[c] = wr_ptr_q[c];
      rd_ptr_d[c] = rd_ptr_q[c];
      count_d[c]  = count_q[c];
      out_d[c]    = out_q[c];
    end
    bcast_d    = '0;
    pop        = '0;
    push       = '0;
    bypass     = '0;
    busy_d     = busy_q;
    overflow_d = overflow_q;

    if (FLUSH) begin
      // Squash wins over STALL, push and alloc; overflow is left alone.
      for (int c = 0; c < 2; c++) begin
        wr_ptr_d[c] = '0;
        rd_ptr_d[c] = '0;
        count_d[c]  = '0;
      end
      busy_d = '1;
    end else begin
      for (int c = 0; c < 2; c++) begin
        pop[c] = !STALL && (count_q[c] != '0);
`ifdef WB_BYPASS_EN
        bypass[c] = !STALL && (count_q[c] == '0) && in_valid[c];
`endif
        // A full FIFO still accepts a push when the head leaves this cycle.
        push[c] = in_valid[c] && !bypass[c] &&
                  ((count_q[c] < CW'(DEPTH)) || pop[c]);
        if (in_valid[c] && !bypass[c] && !push[c]) begin
          overflow_d = 1'b1;
        end

        if (pop[c]) begin
          out_d[c]             = head[c];
          bcast_d[c]           = 1'b1;
          rd_ptr_d[c]          = rd_ptr_q[c] + AW'(1);
          busy_d[head[c].map]  = 1'b1;
        end else if (bypass[c]) begin
          out_d[c]               = in_entry[c];
          bcast_d[c]             = 1'b1;
          busy_d[in_entry[c].map] = 1'b1;
        end

        if (push[c]) begin
          wr_ptr_d[c] = wr_ptr_q[c] + AW'(1);
        end
        count_d[c] = count_q[c] + CW'(push[c]) - CW'(pop[c]);
      end

      // Applied after the broadcast sets so a same-cycle alloc wins.
      if (rename_alloc) begin
        busy_d[rename_alloc_map] = 1'b0;
      end
    end

    // Register 0 is architecturally constant and always ready.
    busy_d[0] = 1'b1;

    for (int c = 0; c < 2; c++) begin
      full_d[c] = (count_d[c] == CW'(DEPTH));
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: state registers use non-blocking assignments so that every flop
    // samples the pre-edge value of every other flop, independent of order.
    if (RESET) begin
      for (int c = 0; c < 2; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        count_q[c]  <= '0;
        out_q[c]    <= '0;
      end
      bcast_q    <= '0;
      full_q     <= '0;
      busy_q     <= '1;
      overflow_q <= 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        count_q[c]  <= count_d[c];
        out_q[c]    <= out_d[c];
      end
      bcast_q    <= bcast_d;
      full_q     <= full_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: FIFO storage has no reset; an entry is only read after it has been
  // written, because the pointers and counts are reset.
  always_ff @(posedge CLK) begin
    for (int c = 0; c < 2; c++) begin
      if (push[c]) begin
        fifo_q[c][wr_ptr_q[c]] <= in_entry[c];
      end
    end
  end

  assign exe_broadcast     = bcast_q[0];
  assign exe_broadcast_map = out_q[0].map;
  assign exe_broadcast_val = out_q[0].val;
  assign mem_broadcast     = bcast_q[1];
  assign mem_broadcast_map = out_q[1].map;
  assign mem_broadcast_val = out_q[1].val;
  assign physreg_we        = bcast_q;
  assign rob_done_exe      = bcast_q[0];
  assign rob_done_exe_num  = out_q[0].num;
  assign rob_done_mem      = bcast_q[1];
  assign rob_done_mem_num  = out_q[1].num;
  assign busy              = busy_q;
  assign exe_full          = full_q[0];
  assign mem_full          = full_q[1];
  assign overflow          = overflow_q;

endmodule

// File: tb/tb_wb_broadcast.sv
// -----------------------------------------------------------------------------
// tb_wb_broadcast
//
// Directed bench for wb_broadcast in its default build (DEPTH = 4, 2-edge
// latency). Inputs change 1 ns after the rising edge, and outputs are
// compared at that same point, well away from the next edge. A stimulus
// table covers single results, dual-channel results, alloc-vs-broadcast,
// map 0 and back-to-back throughput. Hand-written sequences cover STALL with
// overflow, FLUSH and a mid-run RESET.
// -----------------------------------------------------------------------------
module tb_wb_broadcast;

  logic        CLK = 1'b0;
  logic        RESET, STALL, FLUSH;
  logic        exe_valid, mem_valid, rename_alloc;
  logic [5:0]  exe_map, mem_map, rename_alloc_map;
  logic [31:0] exe_val, exe_instr_num, mem_val, mem_instr_num;
  logic        exe_broadcast, mem_broadcast;
  logic [5:0]  exe_broadcast_map, mem_broadcast_map;
  logic [31:0] exe_broadcast_val, mem_broadcast_val;
  logic [1:0]  physreg_we;
  logic        rob_done_exe, rob_done_mem;
  logic [31:0] rob_done_exe_num, rob_done_mem_num;
  logic [63:0] busy;
  logic        exe_full, mem_full, overflow;

  int checks = 0;
  int errors = 0;

  wb_broadcast #(.DEPTH(4)) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .STALL             (STALL),
    .FLUSH             (FLUSH),
    .exe_valid         (exe_valid),
    .exe_map           (exe_map),
    .exe_val           (exe_val),
    .exe_instr_num     (exe_instr_num),
    .mem_valid         (mem_valid),
    .mem_map           (mem_map),
    .mem_val           (mem_val),
    .mem_instr_num     (mem_instr_num),
    .rename_alloc      (rename_alloc),
    .rename_alloc_map  (rename_alloc_map),
    .exe_broadcast     (exe_broadcast),
    .exe_broadcast_map (exe_broadcast_map),
    .exe_broadcast_val (exe_broadcast_val),
    .mem_broadcast     (mem_broadcast),
    .mem_broadcast_map (mem_broadcast_map),
    .mem_broadcast_val (mem_broadcast_val),
    .physreg_we        (physreg_we),
    .rob_done_exe      (rob_done_exe),
    .rob_done_exe_num  (rob_done_exe_num),
    .rob_done_mem      (rob_done_mem),
    .rob_done_mem_num  (rob_done_mem_num),
    .busy              (busy),
    .exe_full          (exe_full),
    .mem_full          (mem_full),
    .overflow          (overflow)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    // stimulus
    logic        ev;
    logic [5:0]  emap;
    logic [31:0] eval;
    logic [31:0] enm;
    logic        mv;
    logic [5:0]  mmap;
    logic [31:0] mval;
    logic [31:0] mnm;
    logic        al;
    logic [5:0]  amap;
    // expected outputs after the edge
    logic        x_ebc;
    logic [5:0]  x_emap;
    logic [31:0] x_eval;
    logic [31:0] x_enm;
    logic        x_mbc;
    logic [5:0]  x_mmap;
    logic [31:0] x_mval;
    logic [31:0] x_mnm;
    logic [1:0]  x_we;
    int          bidx;
    logic        x_b;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    exe_valid = 1'b0; exe_map = '0; exe_val = '0; exe_instr_num = '0;
    mem_valid = 1'b0; mem_map = '0; mem_val = '0; mem_instr_num = '0;
    rename_alloc = 1'b0; rename_alloc_map = '0;
  endtask

  task automatic push_exe(input logic [5:0] m, input logic [31:0] v, input logic [31:0] n);
    exe_valid = 1'b1; exe_map = m; exe_val = v; exe_instr_num = n;
  endtask

  function automatic void set_in(input int i,
      input logic ev, input logic [5:0] emap, input logic [31:0] eval, input logic [31:0] enm,
      input logic mv, input logic [5:0] mmap, input logic [31:0] mval, input logic [31:0] mnm,
      input logic al, input logic [5:0] amap);
    vecs[i].ev = ev; vecs[i].emap = emap; vecs[i].eval = eval; vecs[i].enm = enm;
    vecs[i].mv = mv; vecs[i].mmap = mmap; vecs[i].mval = mval; vecs[i].mnm = mnm;
    vecs[i].al = al; vecs[i].amap = amap;
  endfunction

  function automatic void set_ex(input int i,
      input logic ebc, input logic [5:0] emap, input logic [31:0] eval, input logic [31:0] enm,
      input logic mbc, input logic [5:0] mmap, input logic [31:0] mval, input logic [31:0] mnm,
      input logic [1:0] we, input int bidx, input logic b);
    vecs[i].x_ebc = ebc; vecs[i].x_emap = emap; vecs[i].x_eval = eval; vecs[i].x_enm = enm;
    vecs[i].x_mbc = mbc; vecs[i].x_mmap = mmap; vecs[i].x_mval = mval; vecs[i].x_mnm = mnm;
    vecs[i].x_we = we; vecs[i].bidx = bidx; vecs[i].x_b = b;
  endfunction

  initial begin
    // ---------------- stimulus / expectation table ----------------
    //        ev emap  eval          enm  mv mmap mval   mnm  al amap
    set_in(0,  0, 0,   0,            0,   0, 0,   0,     0,   1, 5);
    set_in(1,  1, 5,   32'hDEADBEEF, 7,   0, 0,   0,     0,   0, 0);
    set_in(2,  0, 0,   0,            0,   0, 0,   0,     0,   0, 0);
    set_in(3,  0, 0,   0,            0,   0, 0,   0,     0,   0, 0);
    set_in(4,  0, 0,   0,            0,   0, 0,   0,     0,   1, 3);
    set_in(5,  0, 0,   0,            0,   0, 0,   0,     0,   1, 9);
    set_in(6,  1, 3,   32'h33,       10,  1, 9,   32'h99, 11, 0, 0);
    set_in(7,  0, 0,   0,            0,   0, 0,   0,     0,   0, 0);
    set_in(8,  0, 0,   0,            0,   0, 0,   0,     0,   0, 0);
    set_in(9,  1, 12,  32'hC0C0,     12,  0, 0,   0,     0,   0, 0);
    set_in(10, 0, 0,   0,            0,   0, 0,   0,     0,   1, 12);
    set_in(11, 0, 0,   0,            0,   1, 0,   32'hAA, 20, 0, 0);
    set_in(12, 0, 0,   0,            0,   0, 0,   0,     0,   0, 0);
    set_in(13, 1, 1,   32'h11,       30,  0, 0,   0,     0,   1, 1);
    set_in(14, 1, 2,   32'h22,       31,  0, 0,   0,     0,   0, 0);
    set_in(15, 0, 0,   0,            0,   0, 0,   0,     0,   0, 0);
    set_in(16, 0, 0,   0,            0,   0, 0,   0,     0,   0, 0);
    //        ebc emap eval          enm  mbc mmap mval    mnm  we     bidx b
    set_ex(0,  0, 0,  0,            0,   0,  0,  0,      0,   2'b00, 5,  0);
    set_ex(1,  0, 0,  0,            0,   0,  0,  0,      0,   2'b00, 5,  0);
    set_ex(2,  1, 5,  32'hDEADBEEF, 7,   0,  0,  0,      0,   2'b01, 5,  1);
    set_ex(3,  0, 5,  32'hDEADBEEF, 7,   0,  0,  0,      0,   2'b00, 5,  1);
    set_ex(4,  0, 5,  32'hDEADBEEF, 7,   0,  0,  0,      0,   2'b00, 3,  0);
    set_ex(5,  0, 5,  32'hDEADBEEF, 7,   0,  0,  0,      0,   2'b00, 9,  0);
    set_ex(6,  0, 5,  32'hDEADBEEF, 7,   0,  0,  0,      0,   2'b00, 3,  0);
    set_ex(7,  1, 3,  32'h33,       10,  1,  9,  32'h99, 11,  2'b11, 3,  1);
    set_ex(8,  0, 3,  32'h33,       10,  0,  9,  32'h99, 11,  2'b00, 9,  1);
    set_ex(9,  0, 3,  32'h33,       10,  0,  9,  32'h99, 11,  2'b00, 12, 1);
    set_ex(10, 1, 12, 32'hC0C0,     12,  0,  9,  32'h99, 11,  2'b01, 12, 0);
    set_ex(11, 0, 12, 32'hC0C0,     12,  0,  9,  32'h99, 11,  2'b00, 0,  1);
    set_ex(12, 0, 12, 32'hC0C0,     12,  1,  0,  32'hAA, 20,  2'b10, 0,  1);
    set_ex(13, 0, 12, 32'hC0C0,     12,  0,  0,  32'hAA, 20,  2'b00, 1,  0);
    set_ex(14, 1, 1,  32'h11,       30,  0,  0,  32'hAA, 20,  2'b01, 1,  1);
    set_ex(15, 1, 2,  32'h22,       31,  0,  0,  32'hAA, 20,  2'b01, 2,  1);
    set_ex(16, 0, 2,  32'h22,       31,  0,  0,  32'hAA, 20,  2'b00, 1,  1);

    // ---------------- reset ----------------
    RESET = 1'b1; STALL = 1'b0; FLUSH = 1'b0;
    idle_inputs();
    tick();
    tick();
    RESET = 1'b0;
    check("rst_exe_broadcast", 64'(exe_broadcast), 64'd0);
    check("rst_mem_broadcast", 64'(mem_broadcast), 64'd0);
    check("rst_physreg_we", 64'(physreg_we), 64'd0);
    check("rst_exe_num", 64'(rob_done_exe_num), 64'd0);
    check("rst_busy", busy, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst_full", 64'({exe_full, mem_full}), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < NV; i++) begin
      exe_valid = vecs[i].ev; exe_map = vecs[i].emap;
      exe_val = vecs[i].eval; exe_instr_num = vecs[i].enm;
      mem_valid = vecs[i].mv; mem_map = vecs[i].mmap;
      mem_val = vecs[i].mval; mem_instr_num = vecs[i].mnm;
      rename_alloc = vecs[i].al; rename_alloc_map = vecs[i].amap;
      tick();
      check($sformatf("v%0d_exe_broadcast", i), 64'(exe_broadcast), 64'(vecs[i].x_ebc));
      check($sformatf("v%0d_exe_map", i), 64'(exe_broadcast_map), 64'(vecs[i].x_emap));
      check($sformatf("v%0d_exe_val", i), 64'(exe_broadcast_val), 64'(vecs[i].x_eval));
      check($sformatf("v%0d_exe_num", i), 64'(rob_done_exe_num), 64'(vecs[i].x_enm));
      check($sformatf("v%0d_mem_broadcast", i), 64'(mem_broadcast), 64'(vecs[i].x_mbc));
      check($sformatf("v%0d_mem_map", i), 64'(mem_broadcast_map), 64'(vecs[i].x_mmap));
      check($sformatf("v%0d_mem_val", i), 64'(mem_broadcast_val), 64'(vecs[i].x_mval));
      check($sformatf("v%0d_mem_num", i), 64'(rob_done_mem_num), 64'(vecs[i].x_mnm));
      check($sformatf("v%0d_physreg_we", i), 64'(physreg_we), 64'(vecs[i].x_we));
      check($sformatf("v%0d_rob_done", i), 64'({rob_done_mem, rob_done_exe}), 64'(vecs[i].x_we));
      check($sformatf("v%0d_busy%0d", i, vecs[i].bidx), 64'(busy[vecs[i].bidx]), 64'(vecs[i].x_b));
      check($sformatf("v%0d_full", i), 64'({exe_full, mem_full}), 64'd0);
      check($sformatf("v%0d_overflow", i), 64'(overflow), 64'd0);
    end
    idle_inputs();

    // ---------------- STALL: fill, overflow, drain in order ----------------
    STALL = 1'b1;
    rename_alloc = 1'b1; rename_alloc_map = 6'd50;
    for (int k = 0; k < 5; k++) begin
      push_exe(6'(40 + k), 32'(40 + k), 32'(100 + k));
      tick();
      rename_alloc = 1'b0;
      check($sformatf("stall_push%0d_broadcast", k), 64'(exe_broadcast), 64'd0);
      check($sformatf("stall_push%0d_full", k), 64'(exe_full), (k >= 3) ? 64'd1 : 64'd0);
      check($sformatf("stall_push%0d_overflow", k), 64'(overflow), (k == 4) ? 64'd1 : 64'd0);
    end
    check("stall_alloc_busy50", 64'(busy[50]), 64'd0);
    idle_inputs();
    STALL = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("drain%0d_broadcast", k), 64'(exe_broadcast), 64'd1);
      check($sformatf("drain%0d_map", k), 64'(exe_broadcast_map), 64'(40 + k));
      check($sformatf("drain%0d_num", k), 64'(rob_done_exe_num), 64'(100 + k));
      check($sformatf("drain%0d_full", k), 64'(exe_full), 64'd0);
    end
    tick();
    check("drain_fifth_dropped", 64'(exe_broadcast), 64'd0);
    check("drain_map_holds", 64'(exe_broadcast_map), 64'd43);
    check("drain_overflow_sticky", 64'(overflow), 64'd1);

    // ---------------- FLUSH with 3 pending entries ----------------
    STALL = 1'b1;
    rename_alloc = 1'b1; rename_alloc_map = 6'd20;
    for (int k = 0; k < 3; k++) begin
      push_exe(6'(21 + k), 32'(21 + k), 32'(200 + k));
      tick();
      rename_alloc = 1'b0;
    end
    check("pre_flush_busy20", 64'(busy[20]), 64'd0);
    // FLUSH beats STALL, and the same-cycle push/alloc are discarded.
    FLUSH = 1'b1;
    push_exe(6'd24, 32'd24, 32'd204);
    mem_valid = 1'b1; mem_map = 6'd26; mem_val = 32'd26; mem_instr_num = 32'd206;
    rename_alloc = 1'b1; rename_alloc_map = 6'd25;
    tick();
    FLUSH = 1'b0; STALL = 1'b0;
    idle_inputs();
    check("flush_broadcasts", 64'({mem_broadcast, exe_broadcast}), 64'd0);
    check("flush_busy_all_ones", busy, 64'hFFFF_FFFF_FFFF_FFFF);
    check("flush_overflow_unchanged", 64'(overflow), 64'd1);
    check("flush_full", 64'(exe_full), 64'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check($sformatf("post_flush%0d_no_bcast", k), 64'({mem_broadcast, exe_broadcast}), 64'd0);
    end
    push_exe(6'd27, 32'd77, 32'd99);
    tick();
    idle_inputs();
    check("post_flush_latency_edge1", 64'(exe_broadcast), 64'd0);
    tick();
    check("post_flush_latency_edge2", 64'(exe_broadcast), 64'd1);
    check("post_flush_map", 64'(exe_broadcast_map), 64'd27);
    check("post_flush_num", 64'(rob_done_exe_num), 64'd99);

    // ---------------- mid-run RESET ----------------
    rename_alloc = 1'b1; rename_alloc_map = 6'd33;
    tick();
    idle_inputs();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("rst2_busy", busy, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst2_overflow", 64'(overflow), 64'd0);
    check("rst2_exe_map", 64'(exe_broadcast_map), 64'd0);
    check("rst2_exe_val", 64'(exe_broadcast_val), 64'd0);
    check("rst2_mem_val", 64'(mem_broadcast_val), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
